// File: rtl/uart_echo_sched_pkg.sv
// Shared types and defaults for the UART echo scheduler.
package uart_sched_pkg;
  localparam int DATA_WD_DEF = 8;
  localparam int CNT_WD_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    WAIT  = 3'd4,
    GAP   = 3'd5
  } state_e;
endpackage

// File: rtl/uart_echo_sched_if.sv
// Receiver / FIFO / transmitter signals seen by the echo scheduler.
interface uart_echo_sched_if #(parameter int DATA_WD = uart_sched_pkg::DATA_WD_DEF);
  logic [DATA_WD-1:0] rx_frame;
  logic               rx_done;
  logic               frame_error;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_WD-1:0] fifo_dout;
  logic               fifo_wr_en;
  logic [DATA_WD-1:0] fifo_din;
  logic               fifo_rd_en;
  logic               tx_frame_en;
  logic [DATA_WD-1:0] tx_data;
  logic               tx_done;

  // master: surrounding receiver, FIFO and transmitter
  modport master (
    output rx_frame, rx_done, frame_error, fifo_full, fifo_empty, fifo_dout, tx_done,
    input  fifo_wr_en, fifo_din, fifo_rd_en, tx_frame_en, tx_data
  );

  // slave: the scheduler itself
  modport slave (
    input  rx_frame, rx_done, frame_error, fifo_full, fifo_empty, fifo_dout, tx_done,
    output fifo_wr_en, fifo_din, fifo_rd_en, tx_frame_en, tx_data
  );
endinterface

// File: rtl/uart_echo_sched_sat_counter.sv
// Status counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt_q <= '0;
    else if (clr_i)                 cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_echo_sched.sv
// Sequences UART rx -> FIFO -> UART tx echo: filtered write path plus a
// one-frame-at-a-time drain FSM with optional gap and tx_done watchdog.
module uart_echo_sched
  import uart_sched_pkg::*;
#(
  parameter int DATA_WD        = DATA_WD_DEF,
  parameter int CNT_WD         = CNT_WD_DEF,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_cnt,
  uart_echo_sched_if.slave  bus,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_WD-1:0] rx_cnt,
  output logic [CNT_WD-1:0] tx_cnt,
  output logic [CNT_WD-1:0] err_cnt,
  output logic [CNT_WD-1:0] ovf_cnt
);
  localparam int WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int NCNT     = 4;

  state_e             state_q;
  logic               rd_en_q, txen_q, tmo_q;
  logic [DATA_WD-1:0] tx_data_q;
  logic [WD_W-1:0]    wdog_q;
  logic [GAP_W-1:0]   gap_q;

  // write path is purely combinational so the strobe lands with rx_done
  logic rx_ok, err_inc, ovf_inc, tx_inc;
  assign rx_ok          = bus.rx_done & en;
  assign bus.fifo_din   = bus.rx_frame;
  assign bus.fifo_wr_en = rx_ok & ~bus.frame_error & ~bus.fifo_full;
  assign err_inc        = rx_ok & bus.frame_error;
  assign ovf_inc        = rx_ok & ~bus.frame_error & bus.fifo_full;
  assign tx_inc         = (state_q == WAIT) & bus.tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      txen_q    <= 1'b0;
      tmo_q     <= 1'b0;
      tx_data_q <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      txen_q  <= 1'b0;
      if (clr_cnt) tmo_q <= 1'b0;
      case (state_q)
        IDLE: if (en && !bus.fifo_empty) begin
          state_q <= READ;
          rd_en_q <= 1'b1;
        end
        READ: state_q <= LATCH;
        LATCH: begin
          tx_data_q <= bus.fifo_dout;
          txen_q    <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            if (!clr_cnt) tmo_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(GAP_LAST)) state_q <= IDLE;
          else                           gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en  = rd_en_q;
  assign bus.tx_frame_en = txen_q;
  assign bus.tx_data     = tx_data_q;
  assign busy            = (state_q != IDLE);
  assign timeout_err     = tmo_q;

  logic [NCNT-1:0]             inc;
  logic [NCNT-1:0][CNT_WD-1:0] cnt;
  assign inc = {ovf_inc, err_inc, tx_inc, bus.fifo_wr_en};

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    sat_counter #(.W(CNT_WD)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc[i]),
      .clr_i (clr_cnt),
      .cnt_o (cnt[i])
    );
  end

  assign rx_cnt  = cnt[0];
  assign tx_cnt  = cnt[1];
  assign err_cnt = cnt[2];
  assign ovf_cnt = cnt[3];
endmodule

// File: doc/uart_echo_sched.md
Name: uart_echo_sched

Overview:
- Controller that sequences the UART receive -> FIFO -> transmit echo path.
- Steers received frames into the shared 8-bit FIFO and drops errored frames and overflows.
- Drains the FIFO into the transmitter one frame at a time, with an explicit read/latch/send/wait handshake, an optional inter-frame gap and a tx_done watchdog.
- Sits between UART_rx, the FIFO and UART_tx in the top level, and exposes status counters.

Parameters:
- DATA_WD, 8, frame width; matches the FRAME_WD define.
- CNT_WD, 16, width of each status counter.
- GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next FIFO read; 0 means no gap.
- TIMEOUT_CYCLES, 200000, maximum clocks spent in WAIT before giving up on tx_done.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  enables new FIFO writes and new drain transfers
- clr_cnt  input  1  synchronous clear of all counters and timeout_err
- rx_frame  input  DATA_WD  received data from the receiver
- rx_done  input  1  one-cycle pulse; rx_frame is valid
- frame_error  input  1  qualifies rx_done; the frame is bad
- fifo_full  input  1  FIFO full flag
- fifo_empty  input  1  FIFO empty flag
- fifo_dout  input  DATA_WD  FIFO read data, valid one clock after fifo_rd_en
- fifo_wr_en  output  1  FIFO write strobe
- fifo_din  output  DATA_WD  FIFO write data
- fifo_rd_en  output  1  FIFO read strobe, one-cycle pulse
- tx_frame_en  output  1  one-cycle start pulse to the transmitter
- tx_data  output  DATA_WD  registered frame presented to the transmitter
- tx_done  input  1  transmitter finished the frame
- busy  output  1  drain FSM is not in IDLE
- timeout_err  output  1  sticky; a WAIT timeout occurred
- rx_cnt, tx_cnt, err_cnt, ovf_cnt  output  CNT_WD each
  - rx_cnt: frames written to the FIFO
  - tx_cnt: frames completed by the transmitter
  - err_cnt: frames dropped because frame_error was set
  - ovf_cnt: frames dropped because the FIFO was full

Behaviour:
- Reset (rst high, asynchronous):
  - FSM goes to IDLE.
  - All outputs, counters, tx_data, timeout_err and internal timers clear to 0.
  - A transfer in progress is abandoned. A frame already read from the FIFO is lost and is not counted.
- Write path (combinational, zero latency):
  - fifo_din = rx_frame.
  - fifo_wr_en = rx_done & en & !frame_error & !fifo_full.
- Write-path accounting, on rx_done & en:
  - frame_error set -> err_cnt +1; nothing is written.
  - frame_error clear and fifo_full set -> ovf_cnt +1.
  - otherwise -> rx_cnt +1.
  - frame_error takes priority over full.
  - rx_done while en is low is ignored and not counted.
- Drain FSM (all outputs registered):
  - IDLE: when en & !fifo_empty, go to READ.
  - READ: fifo_rd_en = 1 for exactly one cycle, then LATCH.
  - LATCH: tx_data <= fifo_dout, then SEND.
  - SEND: tx_frame_en = 1 for exactly one cycle; clear the watchdog; go to WAIT.
  - WAIT: on tx_done, tx_cnt +1 and go to GAP, or to IDLE if GAP_CYCLES = 0. If the watchdog reaches TIMEOUT_CYCLES-1 without tx_done, set timeout_err and go to IDLE; tx_cnt is not incremented.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- Timing:
  - Latency from fifo_empty falling (FSM in IDLE) to the tx_frame_en pulse is 3 clocks (READ, LATCH, SEND).
  - Minimum frame-to-frame spacing is tx_done + 1 + GAP_CYCLES clocks before the next READ.
- tx_done seen outside WAIT is ignored.
- en deasserted mid-transfer: the current frame finishes through WAIT/GAP; no new READ is issued.
- Simultaneous write and drain read are legal in the same cycle; this block needs no arbitration.
- Counters saturate at all-ones and do not wrap.
- clr_cnt beats any increment in the same cycle.
- busy = (state != IDLE).

Decomposition:
- Package uart_sched_pkg holds:
  - the FSM state enum: IDLE, READ, LATCH, SEND, WAIT, GAP;
  - the default DATA_WD and CNT_WD constants.
- One sub-module, sat_counter: parameterised width, with inc and clr inputs and saturate-at-max behaviour. Instantiated four times.

Test Plan:
- Reset mid-WAIT, asserting rst for 1 cycle: all outputs 0 and state IDLE next cycle; the next frame drains normally.
- Single frame with en=1, rx_frame=0xA5, rx_done pulse, FIFO empty before:
  - fifo_wr_en pulses in the same cycle; rx_cnt=1.
  - READ, LATCH and SEND follow, with tx_frame_en 3 clocks after fifo_empty falls and tx_data=0xA5.
  - tx_done gives tx_cnt=1.
- Error and overflow drops:
  - rx_done with frame_error=1 -> err_cnt=1, no fifo_wr_en.
  - rx_done with fifo_full=1 -> ovf_cnt=1, no write.
  - rx_done with both set -> err_cnt=2, ovf_cnt unchanged.
- Back-to-back drain with GAP_CYCLES=4 and 3 frames queued: exactly 3 tx_frame_en pulses; the next READ is 5 clocks after each tx_done; tx_cnt=3.
- Timeout with TIMEOUT_CYCLES=16 and tx_done never asserted: timeout_err=1 on WAIT clock 16, FSM to IDLE, tx_cnt=0. Then clr_cnt clears timeout_err.
- Saturation and enable with CNT_WD=2:
  - 5 good frames -> rx_cnt=3.
  - Drop en mid-WAIT: the frame completes, and no READ follows while fifo_empty=0.
